// File: rtl/mem_bus_pkg.sv
// Shared types and default widths for the external-memory arbiter and the caches.
package mem_bus_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Cache-side request/grant bus plus external-memory port of the arbiter.
// slave = arbiter view, master = caches and memory view.
interface mem_bus_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = mem_bus_pkg::DEF_ADDR_W,
  parameter int DATA_W  = mem_bus_pkg::DEF_DATA_W
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_rw;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic [DATA_W-1:0]         rdata;
  logic                      ext_mem_en;
  logic [ADDR_W-1:0]         ext_mem_addr;
  logic                      ext_mem_rw;
  logic [DATA_W-1:0]         ext_mem_data_in;
  logic [DATA_W-1:0]         ext_mem_data_out;

  modport slave (
    input  req, req_addr, req_rw, req_wdata, ext_mem_data_out,
    output gnt, done, rdata, ext_mem_en, ext_mem_addr, ext_mem_rw, ext_mem_data_in
  );

  modport master (
    output req, req_addr, req_rw, req_wdata, ext_mem_data_out,
    input  gnt, done, rdata, ext_mem_en, ext_mem_addr, ext_mem_rw, ext_mem_data_in
  );
endinterface

// File: rtl/mem_bus_arbiter_rr_select.sv
// Combinational winner select: round-robin from rr_ptr, or a lowest-index-wins
// priority encoder when ARB_FIXED_PRIO_EN is defined (rr_ptr port then disappears).
module rr_select #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
`ifndef ARB_FIXED_PRIO_EN
  input  logic [PTR_W-1:0]   rr_ptr,
`endif
  output logic [NUM_REQ-1:0] win_onehot,
  output logic [PTR_W-1:0]   win_idx,
  output logic               win_valid
);

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    win_valid  = 1'b0;
    // Scan downwards so the lowest requesting index is the last one written.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_onehot    = '0;
        win_onehot[i] = 1'b1;
        win_idx       = PTR_W'(i);
        win_valid     = 1'b1;
      end
    end
  end
`else
  int idx;

  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    win_valid  = 1'b0;
    idx        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_valid && req[idx[PTR_W-1:0]]) begin
        win_onehot[idx[PTR_W-1:0]] = 1'b1;
        win_idx                    = idx[PTR_W-1:0];
        win_valid                  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one fixed-latency external-memory port among NUM_REQ cache requesters.
// Build option: ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
//
// state  | meaning
// IDLE   | no owner; pick a winner from req and latch its address/rw/wdata
// ACCESS | ext_mem_en high for MEM_LAT cycles, read data captured on the last
// DONE   | done pulse to the owner, grant still held, memory strobe off
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MEM_LAT = 2
) (
  input logic              clk,
  input logic              reset,
  mem_bus_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_ACCESS = ACCESS;
  localparam logic [1:0] ST_DONE   = DONE;

  logic [1:0]         state;
  logic [LAT_W-1:0]   lat_cnt;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] done_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               mem_en_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic               mem_rw_q;
  logic [DATA_W-1:0]  mem_wdata_q;

  logic [NUM_REQ-1:0] win_onehot;
  logic [PTR_W-1:0]   win_idx;
  logic               win_valid;

`ifdef ARB_FIXED_PRIO_EN
  rr_select #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_select (
    .req        (bus.req),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .win_valid  (win_valid)
  );
`else
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] rr_ptr_next;

  rr_select #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_select (
    .req        (bus.req),
    .rr_ptr     (rr_ptr),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .win_valid  (win_valid)
  );

  assign rr_ptr_next = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      lat_cnt     <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_rw_q    <= 1'b0;
      mem_wdata_q <= '0;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr      <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            state       <= ST_ACCESS;
            gnt_q       <= win_onehot;
            mem_en_q    <= 1'b1;
            mem_addr_q  <= bus.req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
            mem_rw_q    <= bus.req_rw[win_idx];
            mem_wdata_q <= bus.req_wdata[int'(win_idx)*DATA_W +: DATA_W];
            lat_cnt     <= LAT_W'(MEM_LAT - 1);
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr      <= rr_ptr_next;
`endif
          end
        end
        ST_ACCESS: begin
          // Memory data is only guaranteed valid in the last strobe cycle.
          if (lat_cnt == '0) begin
            state    <= ST_DONE;
            mem_en_q <= 1'b0;
            done_q   <= gnt_q;
            if (!mem_rw_q) rdata_q <= bus.ext_mem_data_out;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          gnt_q  <= '0;
          done_q <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt             = gnt_q;
  assign bus.done            = done_q;
  assign bus.rdata           = rdata_q;
  assign bus.ext_mem_en      = mem_en_q;
  assign bus.ext_mem_addr    = mem_addr_q;
  assign bus.ext_mem_rw      = mem_rw_q;
  assign bus.ext_mem_data_in = mem_wdata_q;

endmodule
